gaussian_nb_mul_arbiter: RTL

Round-robin scheduler that shares one pipelined signed 16x21->37 multiplier among NUM_REQ requesters in the gaussian_nb datapath.
- Accepts at most one operand pair per cycle.
- Tracks the requester ID of each operation through the multiplier pipeline and returns each product to its originator exactly once.
- Sits between the likelihood-computation lanes and the single shared multiplier instance. Drives that instance's din0, din1 and ce, and consumes its dout.

---
 rtl/gaussian_nb_mul_pkg.sv | 22 ++
 rtl/gaussian_nb_rr_arbiter.sv | 35 +++
 rtl/gaussian_nb_mul_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gaussian_nb_mul_pkg.sv
// Shared constants, tag type and pointer helper for the gaussian_nb multiplier arbiter.
// NUM_REQ here sets the tag id width; the top-level NUM_REQ default is taken from it.
package gaussian_nb_mul_pkg;

    localparam int NUM_REQ     = 4;
    localparam int A_WIDTH     = 16;
    localparam int B_WIDTH     = 21;
    localparam int P_WIDTH     = A_WIDTH + B_WIDTH;
    localparam int MUL_LATENCY = 3;
    localparam int CNT_WIDTH   = 32;
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + ID_W'(1);
    endfunction

endpackage

// File: rtl/gaussian_nb_rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr (mod N), gated by en.
// Zero latency; en low forces an empty grant.
module gaussian_nb_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (en && !gnt_vld && req[idx[IW-1:0]]) begin
                gnt_vld               = 1'b1;
                gnt_idx               = idx[IW-1:0];
                gnt[idx[IW-1:0]]      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gaussian_nb_mul_arbiter.sv
// Round-robin front end sharing one pipelined signed multiplier; ids ride a tag pipe beside it.
// Handshake to resp_valid is 1+MUL_LATENCY enabled cycles; ce low freezes everything, responses have no backpressure.
module gaussian_nb_mul_arbiter #(
    parameter int NUM_REQ     = gaussian_nb_mul_pkg::NUM_REQ,
    parameter int A_WIDTH     = gaussian_nb_mul_pkg::A_WIDTH,
    parameter int B_WIDTH     = gaussian_nb_mul_pkg::B_WIDTH,
    parameter int P_WIDTH     = gaussian_nb_mul_pkg::P_WIDTH,
    parameter int MUL_LATENCY = gaussian_nb_mul_pkg::MUL_LATENCY,
    parameter int CNT_WIDTH   = gaussian_nb_mul_pkg::CNT_WIDTH,
    localparam int IF_W       = $clog2(MUL_LATENCY + 2)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [P_WIDTH-1:0]           resp_p,
    output logic [A_WIDTH-1:0]           mul_din0,
    output logic [B_WIDTH-1:0]           mul_din1,
    output logic                         mul_ce,
    input  logic [P_WIDTH-1:0]           mul_dout,
    output logic [IF_W-1:0]              in_flight,
    output logic                         idle,
    output logic [CNT_WIDTH-1:0]         issue_count
);
    import gaussian_nb_mul_pkg::*;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_vld;
    logic [A_WIDTH-1:0]   sel_a;
    logic [B_WIDTH-1:0]   sel_b;
    logic                 rsp_fire;

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    tag_t                 iss_q, iss_d;
    logic [A_WIDTH-1:0]   din0_q, din0_d;
    logic [B_WIDTH-1:0]   din1_q, din1_d;
    tag_t                 tag_q [MUL_LATENCY];
    tag_t                 tag_d [MUL_LATENCY];
    logic [IF_W-1:0]      in_flight_q, in_flight_d;
    logic [CNT_WIDTH-1:0] issue_count_q, issue_count_d;

    gaussian_nb_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (ce),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    assign rsp_fire = ce & tag_q[MUL_LATENCY-1].valid;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        iss_d         = iss_q;
        din0_d        = din0_q;
        din1_d        = din1_q;
        tag_d         = tag_q;
        in_flight_d   = in_flight_q;
        issue_count_d = issue_count_q;
        if (ce) begin
            iss_d.valid = gnt_vld;
            // Stage 0 of the tag pipe lines up with the multiplier's first register.
            tag_d[0] = iss_q;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                tag_d[k] = tag_q[k-1];
            end
            if (gnt_vld) begin
                rr_ptr_d      = next_ptr(gnt_idx, NUM_REQ);
                iss_d.id      = gnt_idx;
                din0_d        = sel_a;
                din1_d        = sel_b;
                issue_count_d = issue_count_q + CNT_WIDTH'(1);
            end
        end
        case ({gnt_vld, rsp_fire})
            2'b10:   in_flight_d = in_flight_q + IF_W'(1);
            2'b01:   in_flight_d = in_flight_q - IF_W'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            iss_q         <= '0;
            din0_q        <= '0;
            din1_q        <= '0;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            in_flight_q   <= '0;
            issue_count_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            iss_q         <= iss_d;
            din0_q        <= din0_d;
            din1_q        <= din1_d;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
            in_flight_q   <= in_flight_d;
            issue_count_q <= issue_count_d;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (rsp_fire) begin
            resp_valid[tag_q[MUL_LATENCY-1].id] = 1'b1;
        end
    end

    assign req_ready   = gnt;
    assign resp_p      = mul_dout;
    assign mul_din0    = din0_q;
    assign mul_din1    = din1_q;
    assign mul_ce      = ce;
    assign in_flight   = in_flight_q;
    assign issue_count = issue_count_q;
    assign idle        = (in_flight_q == '0) && !(|req_valid);

endmodule
